// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } btn_state_t;

  localparam int unsigned DEB_10MS_100MHZ = 1_000_000;
  localparam int unsigned LONG_1S_100MHZ  = 100_000_000;

endpackage

// File: rtl/button_conditioner_if.sv
// Button pin and conditioned outputs; the conditioner takes the slave side.
interface button_conditioner_if;

  logic din;
  logic level;
  logic rising;
  logic falling;
  logic long;

  modport master (
    output din,
    input  level,
    input  rising,
    input  falling,
    input  long
  );

  modport slave (
    input  din,
    output level,
    output rising,
    output falling,
    output long
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for asynchronous single-bit pins, cleared by synchronous reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounced level plus press/release pulses for one mechanical button.
// Optional long-press pulse is built only when BUTTON_LONGPRESS_EN is defined.
//
// state       | meaning
// STABLE_LOW  | button committed released
// WAIT_HIGH   | input high, debouncing a press
// STABLE_HIGH | button committed pressed
// WAIT_LOW    | input low, debouncing a release
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEB_10MS_100MHZ,
  parameter int unsigned LONG_CYCLES = LONG_1S_100MHZ
) (
  input logic                 clock,
  input logic                 reset,
  button_conditioner_if.slave bus
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  btn_state_t    state;
  logic [CW-1:0] cnt;
  logic          din_s;
  logic          deb_done;
  logic          level_r;
  logic          rising_r;
  logic          falling_r;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.din),
    .q     (din_s)
  );

  assign deb_done = (cnt == DEB_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= STABLE_LOW;
      cnt       <= '0;
      level_r   <= 1'b0;
      rising_r  <= 1'b0;
      falling_r <= 1'b0;
    end else begin
      rising_r  <= 1'b0;
      falling_r <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (din_s) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!din_s) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (deb_done) begin
            state    <= STABLE_HIGH;
            cnt      <= '0;
            level_r  <= 1'b1;
            rising_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!din_s) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (din_s) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (deb_done) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            level_r   <= 1'b0;
            falling_r <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.level   = level_r;
  assign bus.rising  = rising_r;
  assign bus.falling = falling_r;

`ifdef BUTTON_LONGPRESS_EN
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold;
  logic          long_done;
  logic          long_r;
  logic          enter_high;
  logic          leave_high;

  assign enter_high = (state == WAIT_HIGH) && din_s && deb_done;
  assign leave_high = (state == WAIT_LOW) && !din_s && deb_done;

  // A release committing on the terminal hold cycle wins: no long pulse alongside falling.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold      <= '0;
      long_done <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      long_r <= 1'b0;
      if (enter_high || leave_high) begin
        hold      <= '0;
        long_done <= 1'b0;
      end else if ((state == STABLE_HIGH) || (state == WAIT_LOW)) begin
        if (hold != HOLD_LAST) begin
          hold <= hold + 1'b1;
        end else if (!long_done) begin
          long_r    <= 1'b1;
          long_done <= 1'b1;
        end
      end
    end
  end

  assign bus.long = long_r;
`else
  // Without long-press support LONG_CYCLES has no effect and long stays low.
  assign bus.long = (LONG_CYCLES == 0) & 1'b0;
`endif

endmodule
